// File: rtl/vote_collector.sv
// Four-voter yes/no ballot collector with a bounded voting window.
// A session opens on start, latches one vote per voter, and closes on all-voted, close request or timeout.
module vote_collector #(
    parameter logic [15:0] WINDOW = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       close,
    input  logic [3:0] btn_yes,
    input  logic [3:0] btn_no,
    output logic [3:0] votes,
    output logic [3:0] voted,
    output logic       busy,
    output logic       done,
    output logic [1:0] reason
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OPEN = 2'b01,
        HOLD = 2'b10
    } state_t;

    localparam logic [15:0] TIMER_LAST = WINDOW - 16'd1;
    localparam logic [15:0] TIMER_MAX  = 16'hFFFF;

    localparam logic [1:0] REASON_NONE    = 2'b00;
    localparam logic [1:0] REASON_ALL     = 2'b01;
    localparam logic [1:0] REASON_CLOSE   = 2'b10;
    localparam logic [1:0] REASON_TIMEOUT = 2'b11;

    state_t      state_q, state_d;
    logic [3:0]  votes_q, votes_d;
    logic [3:0]  voted_q, voted_d;
    logic [1:0]  reason_q, reason_d;
    logic [15:0] timer_q, timer_d;
    logic        done_q, done_d;

    logic [3:0]  accept;
    logic [3:0]  voted_open;
    logic [3:0]  votes_open;
    logic        all_voted;
    logic        timed_out;

    // A voter's press counts only once per session and only when exactly one button is held.
    always_comb begin
        accept     = ~voted_q & (btn_yes ^ btn_no);
        voted_open = voted_q | accept;
        votes_open = votes_q | (accept & btn_yes);
        all_voted  = (voted_open == 4'b1111);
        timed_out  = (timer_q == TIMER_LAST);
    end

    always_comb begin
        state_d  = state_q;
        votes_d  = votes_q;
        voted_d  = voted_q;
        reason_d = reason_q;
        timer_d  = timer_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    state_d  = OPEN;
                    votes_d  = 4'b0000;
                    voted_d  = 4'b0000;
                    reason_d = REASON_NONE;
                    timer_d  = 16'd0;
                end
            end

            OPEN: begin
                votes_d = votes_open;
                voted_d = voted_open;
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 16'd1;
                end
                // Votes arriving with the closing event are kept; reason follows fixed priority.
                if (all_voted || close || timed_out) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    if (all_voted) begin
                        reason_d = REASON_ALL;
                    end else if (close) begin
                        reason_d = REASON_CLOSE;
                    end else begin
                        reason_d = REASON_TIMEOUT;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            votes_q  <= 4'b0000;
            voted_q  <= 4'b0000;
            reason_q <= REASON_NONE;
            timer_q  <= 16'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            votes_q  <= votes_d;
            voted_q  <= voted_d;
            reason_q <= reason_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
        end
    end

    assign votes  = votes_q;
    assign voted  = voted_q;
    assign busy   = (state_q == OPEN);
    assign done   = done_q;
    assign reason = reason_q;

endmodule
